// File: rtl/glb_st_dma_packer_pkg.sv
// ---------------------------------------------------------------------------
// glb_st_dma_packer_pkg
// Shared definitions for the global buffer store-DMA write packer.
//   - global buffer widths (stream word, bank word, strobes, address, length)
//   - st_pack_state_e : packer FSM states
//   - st_pack_entry_t : one packed bank write {addr, data, strb}
//   - bank_align()    : clears the byte offset inside a bank word
// ---------------------------------------------------------------------------
package glb_st_dma_packer_pkg;

  localparam int CGRA_DATA_WIDTH      = 16;
  localparam int BANK_DATA_WIDTH      = 64;
  localparam int BANK_STRB_WIDTH      = 8;
  localparam int GLB_ADDR_WIDTH       = 19;
  localparam int STORE_DMA_FIFO_DEPTH = 4;
  localparam int NUM_WORDS_WIDTH      = 16;

  localparam int LANES         = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
  localparam int STRB_PER_LANE = CGRA_DATA_WIDTH / 8;
  localparam int BYTE_OFF_BITS = $clog2(BANK_STRB_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } st_pack_state_e;

  typedef struct packed {
    logic [GLB_ADDR_WIDTH-1:0]  addr;
    logic [BANK_DATA_WIDTH-1:0] data;
    logic [BANK_STRB_WIDTH-1:0] strb;
  } st_pack_entry_t;

  function automatic logic [GLB_ADDR_WIDTH-1:0] bank_align(input logic [GLB_ADDR_WIDTH-1:0] a);
    return a & ~GLB_ADDR_WIDTH'(BANK_STRB_WIDTH - 1);
  endfunction

endpackage

// File: rtl/glb_st_dma_packer_if.sv
// ---------------------------------------------------------------------------
// glb_st_dma_packer_if
// Bundles the packer's configuration, stream and bank-write signals.
//   cfg_*   : start pulse, byte start address, stream word count
//   strm_*  : 16-bit ready/valid stream into the packer
//   wr_*    : 64-bit bank write port with byte strobes
//   busy_out / done_pulse_out : transfer status
// Modports: slave = the packer itself, master = the surrounding tile/bench.
// ---------------------------------------------------------------------------
interface glb_st_dma_packer_if
  import glb_st_dma_packer_pkg::*;
;
  logic                       cfg_start;
  logic [GLB_ADDR_WIDTH-1:0]  cfg_start_addr;
  logic [NUM_WORDS_WIDTH-1:0] cfg_num_words;
  logic [CGRA_DATA_WIDTH-1:0] strm_data_in;
  logic                       strm_valid_in;
  logic                       strm_ready_out;
  logic                       wr_en_out;
  logic [GLB_ADDR_WIDTH-1:0]  wr_addr_out;
  logic [BANK_DATA_WIDTH-1:0] wr_data_out;
  logic [BANK_STRB_WIDTH-1:0] wr_strb_out;
  logic                       wr_ready_in;
  logic                       busy_out;
  logic                       done_pulse_out;

  modport slave (
    input  cfg_start, cfg_start_addr, cfg_num_words,
    input  strm_data_in, strm_valid_in, wr_ready_in,
    output strm_ready_out, wr_en_out, wr_addr_out, wr_data_out, wr_strb_out,
    output busy_out, done_pulse_out
  );

  modport master (
    output cfg_start, cfg_start_addr, cfg_num_words,
    output strm_data_in, strm_valid_in, wr_ready_in,
    input  strm_ready_out, wr_en_out, wr_addr_out, wr_data_out, wr_strb_out,
    input  busy_out, done_pulse_out
  );

endinterface

// File: rtl/glb_st_pack_fifo.sv
// ---------------------------------------------------------------------------
// glb_st_pack_fifo
// Synchronous first-word-fall-through FIFO for packed bank writes.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : enqueue (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   full, empty, last : occupancy flags (last = exactly one entry)
// ---------------------------------------------------------------------------
module glb_st_pack_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign last    = (count == CNT_W'(1));
  assign dout    = mem[rd_ptr];

  // Storage array: no reset needed, the empty flag hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/glb_st_dma_packer.sv
// ---------------------------------------------------------------------------
// glb_st_dma_packer
// Store-DMA write packer: gathers 16-bit stream words into 64-bit bank words
// with byte strobes, queues them in a small FIFO and issues them to the bank.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : glb_st_dma_packer_if.slave (cfg, stream in, bank write out, status)
// ---------------------------------------------------------------------------
module glb_st_dma_packer
  import glb_st_dma_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = STORE_DMA_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  glb_st_dma_packer_if.slave   bus
);

  st_pack_state_e             state;
  st_pack_state_e             state_next;
  logic [GLB_ADDR_WIDTH-1:0]  addr;
  logic [NUM_WORDS_WIDTH-1:0] remaining;
  logic [BANK_DATA_WIDTH-1:0] pack_data;
  logic [BANK_STRB_WIDTH-1:0] pack_strb;
  logic [BANK_DATA_WIDTH-1:0] merged_data;
  logic [BANK_STRB_WIDTH-1:0] merged_strb;
  logic [BYTE_OFF_BITS-2:0]   lane;
  logic                       done_q;
  logic                       strm_ready;
  logic                       busy;
  logic                       accept;
  logic                       last_word;
  logic                       push;
  logic                       pop;
  logic                       start_go;
  logic                       start_zero;
  logic                       drain_done;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_last;
  st_pack_entry_t             push_entry;
  st_pack_entry_t             head_entry;

  assign lane       = addr[BYTE_OFF_BITS-1:1];
  assign start_go   = (state == ST_IDLE) && bus.cfg_start && (bus.cfg_num_words != '0);
  assign start_zero = (state == ST_IDLE) && bus.cfg_start && (bus.cfg_num_words == '0);
  assign accept     = bus.strm_valid_in && strm_ready;
  assign last_word  = (remaining == NUM_WORDS_WIDTH'(1));
  assign push       = accept && ((lane == (BYTE_OFF_BITS-1)'(LANES - 1)) || last_word);
  assign pop        = !fifo_empty && bus.wr_ready_in;
  // The pop of the final entry ends the drain, so IDLE is reached as done rises.
  assign drain_done = (state == ST_DRAIN) && (fifo_empty || (fifo_last && pop));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start, last accepted word, FIFO drained.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start_go) state_next = ST_ACTIVE;
      ST_ACTIVE: if (accept && last_word) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs. Full ignores a same-cycle pop, trading a bubble for
  // a ready that depends only on registers.
  always_comb begin
    strm_ready = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_ACTIVE: begin
        strm_ready = !fifo_full;
        busy       = 1'b1;
      end
      ST_DRAIN:  busy = 1'b1;
      default:   ;
    endcase
  end

  // Pack buffer with the incoming word merged into its lane.
  always_comb begin
    merged_data = pack_data;
    merged_strb = pack_strb;
    merged_data[lane*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = bus.strm_data_in;
    merged_strb[lane*STRB_PER_LANE +: STRB_PER_LANE]     = '1;
    push_entry.addr = bank_align(addr);
    push_entry.data = merged_data;
    push_entry.strb = merged_strb;
  end

  // Transfer datapath: address/count tracking, pack buffer and done pulse.
  // Address advance wraps naturally at the top of the byte address space.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= start_zero || drain_done;
      if (start_go) begin
        addr      <= bus.cfg_start_addr & ~GLB_ADDR_WIDTH'(1);
        remaining <= bus.cfg_num_words;
        pack_data <= '0;
        pack_strb <= '0;
      end else if (accept) begin
        addr      <= addr + GLB_ADDR_WIDTH'(2);
        remaining <= remaining - NUM_WORDS_WIDTH'(1);
        if (push) begin
          pack_data <= '0;
          pack_strb <= '0;
        end else begin
          pack_data <= merged_data;
          pack_strb <= merged_strb;
        end
      end
    end
  end

  glb_st_pack_fifo #(
    .WIDTH ($bits(st_pack_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last)
  );

  // Head entry is masked so the write port reads all-zero while nothing is queued.
  assign bus.strm_ready_out = strm_ready;
  assign bus.busy_out       = busy;
  assign bus.done_pulse_out = done_q;
  assign bus.wr_en_out      = !fifo_empty;
  assign bus.wr_addr_out    = fifo_empty ? '0 : head_entry.addr;
  assign bus.wr_data_out    = fifo_empty ? '0 : head_entry.data;
  assign bus.wr_strb_out    = fifo_empty ? '0 : head_entry.strb;

endmodule

// File: tb/tb_glb_st_dma_packer.sv
// ---------------------------------------------------------------------------
// tb_glb_st_dma_packer
// Scoreboard bench for the store-DMA packer. Each transfer's expected bank
// writes are derived by grouping stream words by the bank word they fall in
// and queued; a free-running monitor pops and compares on every bank write.
// ---------------------------------------------------------------------------
module tb_glb_st_dma_packer;

  typedef logic [15:0] word_q_t[$];
  typedef struct {
    logic [18:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } exp_t;

  logic clk;
  logic rst_n;
  glb_st_dma_packer_if bus ();

  glb_st_dma_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   done_count = 0;
  int   accepted = 0;
  int   ready_mode = 0;
  bit   expect_pop_done = 1;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bank-side ready: always, random, or held off.
  initial begin
    bus.wr_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.wr_ready_in = 1'b1;
        1:       bus.wr_ready_in = ($urandom_range(99) < 60);
        default: bus.wr_ready_in = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard compare on each bank write, write-hold during stalls,
  // and done-pulse timing relative to the last write.
  initial begin
    logic        stall_prev;
    logic        done_prev;
    logic [18:0] h_addr;
    logic [63:0] h_data;
    logic [7:0]  h_strb;
    exp_t        e;
    stall_prev = 1'b0;
    done_prev  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (stall_prev) begin
          checkOutput("hold_en", bus.wr_en_out, 1);
          checkOutput("hold_addr", bus.wr_addr_out, h_addr);
          checkOutput("hold_data", bus.wr_data_out, h_data);
          checkOutput("hold_strb", bus.wr_strb_out, h_strb);
        end
        if (bus.wr_en_out && bus.wr_ready_in) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_write_addr", bus.wr_addr_out, 19'h7FFFF + 64'h1);
          end else begin
            e = sb.pop_front();
            checkOutput("wr_addr", bus.wr_addr_out, e.addr);
            checkOutput("wr_data", bus.wr_data_out, e.data);
            checkOutput("wr_strb", bus.wr_strb_out, e.strb);
          end
          last_pop_cyc = cyc;
        end
        if (bus.done_pulse_out) begin
          done_count++;
          checkOutput("done_width", {done_prev, bus.done_pulse_out}, 2'b01);
          if (expect_pop_done) begin
            checkOutput("done_gap", cyc - last_pop_cyc, 1);
            checkOutput("done_sb_empty", sb.size(), 0);
          end
        end
      end
      stall_prev = rst_n && bus.wr_en_out && !bus.wr_ready_in;
      done_prev  = rst_n && bus.done_pulse_out;
      h_addr     = bus.wr_addr_out;
      h_data     = bus.wr_data_out;
      h_strb     = bus.wr_strb_out;
    end
  end

  // Reference model: each stream word lands at its byte address; consecutive
  // words sharing a bank word form one write, unwritten lanes are zero.
  task automatic modelTransfer(input logic [18:0] start, input word_q_t d);
    exp_t        cur;
    bit          have;
    logic [18:0] a;
    logic [18:0] b;
    int          ln;
    have = 0;
    a = start & ~19'h1;
    foreach (d[i]) begin
      b  = {a[18:3], 3'b000};
      ln = int'(a[2:1]);
      if (have && (b != cur.addr)) begin
        sb.push_back(cur);
        have = 0;
      end
      if (!have) begin
        cur.addr = b;
        cur.data = '0;
        cur.strb = '0;
        have = 1;
      end
      cur.data[ln*16 +: 16] = d[i];
      cur.strb[ln*2 +: 2]   = 2'b11;
      a = a + 19'd2;
    end
    if (have) sb.push_back(cur);
  endtask

  function automatic word_q_t randomData(input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
    return q;
  endfunction

  task automatic startCfg(input logic [18:0] a, input logic [15:0] n);
    @(posedge clk);
    #1;
    bus.cfg_start      = 1'b1;
    bus.cfg_start_addr = a;
    bus.cfg_num_words  = n;
    @(posedge clk);
    #1;
    bus.cfg_start = 1'b0;
  endtask

  task automatic sendWords(input word_q_t d, input int gap_pct);
    bit ok;
    int w;
    foreach (d[i]) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        bus.strm_valid_in = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.strm_valid_in = 1'b1;
      bus.strm_data_in  = d[i];
      w = 0;
      do begin
        @(negedge clk);
        ok = bus.strm_ready_out;
        @(posedge clk);
        #1;
        w++;
      end while (!ok && w < 500);
      if (!ok) begin
        checkOutput("stream_accept_timeout", ok, 1);
        bus.strm_valid_in = 1'b0;
        return;
      end
      accepted++;
    end
    bus.strm_valid_in = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int d0;
    int k;
    d0 = done_count;
    k = 0;
    while (done_count == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checkOutput("done_seen", done_count - d0, 1);
  endtask

  // One full transfer: queue expectations, start, stream, await completion.
  // With bogus set, a second start is issued mid-transfer and must be ignored.
  task automatic applyStimulus(input logic [18:0] a, input word_q_t d, input int gap_pct, input bit bogus);
    modelTransfer(a, d);
    startCfg(a, 16'(d.size()));
    if (bogus) begin
      fork
        sendWords(d, gap_pct);
        begin
          repeat (3) @(posedge clk);
          #1;
          bus.cfg_start      = 1'b1;
          bus.cfg_start_addr = 19'h05554;
          bus.cfg_num_words  = 16'd7;
          @(negedge clk);
          checkOutput("busy_active", bus.busy_out, 1);
          @(posedge clk);
          #1;
          bus.cfg_start = 1'b0;
        end
      join
    end else begin
      sendWords(d, gap_pct);
    end
    waitDone(400);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_strm_ready"}, bus.strm_ready_out, 0);
    checkOutput({tag, "_wr_en"}, bus.wr_en_out, 0);
    checkOutput({tag, "_wr_addr"}, bus.wr_addr_out, 0);
    checkOutput({tag, "_wr_data"}, bus.wr_data_out, 0);
    checkOutput({tag, "_wr_strb"}, bus.wr_strb_out, 0);
    checkOutput({tag, "_busy"}, bus.busy_out, 0);
    checkOutput({tag, "_done"}, bus.done_pulse_out, 0);
  endtask

  initial begin
    word_q_t d;
    int      acc0;
    int      d0;
    logic [18:0] ra;

    rst_n              = 1'b0;
    bus.cfg_start      = 1'b0;
    bus.cfg_start_addr = '0;
    bus.cfg_num_words  = '0;
    bus.strm_data_in   = '0;
    bus.strm_valid_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] aligned transfer");
    d = {};
    for (int i = 1; i <= 8; i++) d.push_back(16'(i));
    applyStimulus(19'h00100, d, 0, 0);

    $display("[TB] unaligned head and tail");
    d = {16'hAAAA, 16'hBBBB, 16'hCCCC};
    applyStimulus(19'h00104, d, 0, 0);

    $display("[TB] backpressure");
    d = randomData(32);
    modelTransfer(19'h01000, d);
    ready_mode = 2;
    startCfg(19'h01000, 16'd32);
    acc0 = accepted;
    fork
      sendWords(d, 0);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_accepts", accepted - acc0, 16);
        checkOutput("bp_ready_low", bus.strm_ready_out, 0);
        checkOutput("bp_wr_en", bus.wr_en_out, 1);
        ready_mode = 0;
      end
    join
    waitDone(400);

    $display("[TB] zero-length start");
    expect_pop_done = 0;
    d0 = done_count;
    startCfg(19'h00040, 16'd0);
    @(negedge clk);
    checkOutput("zero_done", bus.done_pulse_out, 1);
    checkOutput("zero_busy", bus.busy_out, 0);
    @(negedge clk);
    checkOutput("zero_done_low", bus.done_pulse_out, 0);
    checkOutput("zero_done_count", done_count - d0, 1);
    expect_pop_done = 1;

    $display("[TB] ignored start during transfer");
    applyStimulus(19'h00208, randomData(12), 0, 1);

    $display("[TB] address wrap");
    applyStimulus(19'h7FFFC, randomData(4), 0, 0);

    $display("[TB] mid-transfer reset");
    d = randomData(12);
    modelTransfer(19'h00300, d);
    startCfg(19'h00300, 16'd12);
    d = d[0:5];
    sendWords(d, 0);
    rst_n = 1'b0;
    sb.delete();
    d0 = done_count;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    repeat (5) @(negedge clk);
    checkOutput("midreset_no_done", done_count - d0, 0);
    applyStimulus(19'h00402, randomData(9), 20, 0);

    $display("[TB] random transfers");
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      ra = 19'($urandom);
      applyStimulus(ra, randomData($urandom_range(1, 20)), 30, 0);
    end
    ready_mode = 0;

    repeat (3) @(negedge clk);
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glb_st_dma_packer.md
# glb_st_dma_packer

Store-DMA write packer for the global buffer tile. It accepts 16-bit CGRA stream words over ready/valid and packs them into 64-bit bank words with byte strobes. Packed words are buffered in a small FIFO and issued to the bank write port. It sits between the CGRA-facing store stream and the tile's bank write mux. Widths come from the global buffer parameter package.

## Interface

**Parameters**
- CGRA_DATA_WIDTH, 16, stream word width
- BANK_DATA_WIDTH, 64, bank word width
- BANK_STRB_WIDTH, 8, byte strobes per bank word
- GLB_ADDR_WIDTH, 19, byte address width
- FIFO_DEPTH, 4 (STORE_DMA_FIFO_DEPTH), packed-word FIFO entries
- NUM_WORDS_WIDTH, 16, transfer length counter width

**Ports**
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset; synchronous, active-low
- cfg_start  in  1  one-cycle start pulse, honoured only in IDLE
- cfg_start_addr  in  19  byte start address; bit 0 ignored
- cfg_num_words  in  16  number of 16-bit stream words
- strm_data_in  in  16  stream data
- strm_valid_in  in  1  stream valid
- strm_ready_out  out  1  stream ready
- wr_en_out  out  1  bank write request (FIFO head valid)
- wr_addr_out  out  19  bank-word-aligned byte address (bits [2:0] = 0)
- wr_data_out  out  64  packed data
- wr_strb_out  out  8  byte strobes
- wr_ready_in  in  1  bank accepts the head entry this cycle
- busy_out  out  1  high in ACTIVE or DRAIN
- done_pulse_out  out  1  one-cycle completion pulse

## Operation

- **FSM states:** IDLE, ACTIVE, DRAIN.
- **IDLE -> ACTIVE** on cfg_start with num_words > 0.
  - Latch addr = cfg_start_addr & ~1 and remaining = num_words.
  - Clear the pack buffer.
- **IDLE, num_words = 0:** cfg_start raises done_pulse_out the next cycle and the FSM stays in IDLE.
- **cfg_start outside IDLE** is ignored.
- **Stream ready:** strm_ready_out = (state == ACTIVE) && !fifo_full. An accept is strm_valid_in && strm_ready_out.
- **On each accept:**
  - lane = addr[2:1]; write data into pack bits [16*lane +: 16].
  - Set strobe bits [2*lane +: 2].
  - Advance addr by 2, modulo 2^19; decrement remaining.
- **Packed-word push:** the pack buffer is pushed to the FIFO with address = old addr & ~7 when either holds:
  - lane == 3, or
  - remaining becomes 0.
  - After the push, pack data and strobes clear.
- **Partial words:** an unaligned start or a short tail produces partial strobes. Unwritten lanes carry 0 data.
- **ACTIVE -> DRAIN** on the accept that makes remaining 0.
- **DRAIN -> IDLE** when the FIFO is empty. done_pulse_out is asserted on that transition cycle.
- **FIFO:** wr_en_out = !fifo_empty; the head entry drives wr_addr/data/strb. Pop when wr_en_out && wr_ready_in.
  - Push and pop in the same cycle are both honoured.
  - fifo_full ignores a same-cycle pop, which conservatively costs one bubble.
- **Address wrap:** 0x7FFFE + 2 wraps to 0x00000 and is handled as a lane-3 boundary.

## Timing

- **Reset values (rst_n low at a clock edge):**
  - state = IDLE; FIFO empty; pack buffer cleared.
  - All outputs 0: strm_ready_out, wr_en_out, wr_addr_out, wr_data_out, wr_strb_out, busy_out, done_pulse_out.
- **Reset mid-transfer** abandons the transfer with no done pulse, and FIFO contents are discarded.
- **Start latency:** cfg_start at cycle t gives busy_out = 1 and strm_ready_out = 1 (if FIFO not full) at t+1.
- **Write latency:** an accept that completes a bank word at cycle t gives wr_en_out = 1 with that entry at t+1.
- **Throughput:** one stream word per cycle; one bank write per four words when aligned.
- **Completion:** done_pulse_out rises the cycle after the final FIFO pop and lasts exactly one cycle. The next cfg_start is honoured that same cycle (state is already IDLE).
- **Write hold:** wr_* must hold stable while wr_en_out && !wr_ready_in.

## Structure

- **Shared package:**
  - Widths come from the global buffer parameter package: CGRA_DATA_WIDTH, BANK_DATA_WIDTH, BANK_STRB_WIDTH, GLB_ADDR_WIDTH, STORE_DMA_FIFO_DEPTH.
  - Add the packed entry struct st_pack_entry_t {addr, data, strb} and the FSM enum st_pack_state_e to the same package.
- **Sub-module:** one sub-module, glb_st_pack_fifo. It is a synchronous FIFO parameterised by width and depth, with push/pop/full/empty and first-word-fall-through output.

## Test plan

- **Aligned transfer:** start_addr = 0x100, num_words = 8, data 1..8 with valid held high, wr_ready_in = 1.
  - Two writes: addr 0x100, data 0x0004_0003_0002_0001, strb 0xFF; then addr 0x108, data 0x0008_0007_0006_0005, strb 0xFF.
  - done_pulse_out one cycle after the second write.
- **Unaligned head and tail:** start_addr = 0x104, num_words = 3, data A, B, C.
  - Write addr 0x100, strb 0xF0, data lanes 2-3 = A, B.
  - Write addr 0x108, strb 0x03, lane 0 = C.
- **Backpressure:** wr_ready_in = 0 for 20 cycles, num_words = 32.
  - strm_ready_out drops after 16 accepts (4 FIFO entries).
  - wr_* stay stable; no data lost after release; 8 writes in order.
- **Zero-length and ignored start:** cfg_start with num_words = 0 gives done_pulse_out at t+1 and busy_out stays 0. A second cfg_start during ACTIVE changes neither address nor count.
- **Address wrap:** start_addr = 0x7FFFC, num_words = 4.
  - Writes at 0x7FFF8 (strb 0xF0) and 0x00000 (strb 0x0F).
- **Mid-transfer reset:** rst_n low for 1 cycle mid-transfer.
  - All outputs 0 the next cycle; no done pulse.
  - A fresh transfer then completes correctly.
